cpx_accumulate: RTL and testbench

- Integrate-and-dump stage directly downstream of the complex multiplier in the CAF datapath.
- Sums `length` consecutive complex products per I and Q, then presents one scaled complex sum per block to the next stage.
- Uses the same valid/ready handshake naming as the multiplier.

---
 rtl/caf_pkg.sv | 21 ++
 rtl/cpx_accumulate_if.sv | 30 +++
 rtl/cpx_acc_lane.sv | 63 ++++++
 rtl/cpx_accumulate.sv | 99 +++++++++
 tb/tb_cpx_accumulate.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/caf_pkg.sv
// Shared CAF datapath definitions: accumulator FSM encoding, default block
// length and a constant clog2 helper.
package caf_pkg;

  localparam int CAF_LENGTH = 1024;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpx_accumulate_if.sv
// Sample/sum bus of the complex integrate-and-dump stage.
interface cpx_accumulate_if #(
  parameter int i_bits     = 24,
  parameter int q_bits     = 24,
  parameter int out_i_bits = 34,
  parameter int out_q_bits = 34
);
  // Handshake: a sample transfers on a rising edge where m_axis_tvalid &&
  // s_axis_tready; a sum transfers where s_axis_tvalid && m_axis_tready.
  // Once raised, s_axis_tvalid and i_sum/q_sum hold until transferred.
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic signed [i_bits-1:0]     i;
  logic signed [q_bits-1:0]     q;
  logic                         s_axis_tready;
  logic                         s_axis_tvalid;
  logic signed [out_i_bits-1:0] i_sum;
  logic signed [out_q_bits-1:0] q_sum;
  logic                         block_last;

  modport slave (
    input  m_axis_tvalid, m_axis_tready, i, q,
    output s_axis_tready, s_axis_tvalid, i_sum, q_sum, block_last
  );

  modport master (
    output m_axis_tvalid, m_axis_tready, i, q,
    input  s_axis_tready, s_axis_tvalid, i_sum, q_sum, block_last
  );
endinterface

// File: rtl/cpx_acc_lane.sv
// One accumulator lane: running sum, scaled output register and a parked
// result register. Rounding is enabled by CPX_ACCUMULATE_ROUND_EN.
module cpx_acc_lane #(
  parameter int in_bits     = 24,
  parameter int length_bits = 10,
  parameter int shift       = 0,
  parameter int out_bits    = in_bits + length_bits - shift
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [in_bits-1:0]  sample_i,
  input  logic                       accept_i,
  input  logic                       first_i,
  input  logic                       load_out_i,
  input  logic                       park_i,
  input  logic                       unpark_i,
  output logic signed [out_bits-1:0] sum_o
);
  localparam int acc_bits = in_bits + length_bits;

  logic signed [acc_bits-1:0] sample_ext, total, acc_q, acc_d;
  logic signed [out_bits-1:0] scaled, park_q, park_d, out_q, out_d;

  assign sample_ext = {{length_bits{sample_i[in_bits-1]}}, sample_i};
  // The first sample of a block overwrites the sum, so no clear cycle is needed.
  assign total      = first_i ? sample_ext : acc_q + sample_ext;
  assign acc_d      = accept_i ? total : acc_q;

`ifdef CPX_ACCUMULATE_ROUND_EN
  if (shift > 0) begin : g_round
    localparam logic signed [acc_bits:0] half = (acc_bits + 1)'(1) << (shift - 1);
    logic signed [acc_bits:0] biased;
    assign biased = {total[acc_bits-1], total} + half;
    assign scaled = out_bits'(biased >>> shift);
  end else begin : g_plain
    assign scaled = out_bits'(total);
  end
`else
  assign scaled = out_bits'(total >>> shift);
`endif

  assign park_d = park_i ? scaled : park_q;

  always_comb begin
    out_d = out_q;
    if (load_out_i)    out_d = scaled;
    else if (unpark_i) out_d = park_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      park_q <= '0;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      park_q <= park_d;
      out_q  <= out_d;
    end
  end

  assign sum_o = out_q;
endmodule

// File: rtl/cpx_accumulate.sv
// Complex integrate-and-dump: sums `length` samples per I/Q and emits one
// scaled sum per block, with one sum of queueing. Option: CPX_ACCUMULATE_ROUND_EN.
module cpx_accumulate
  import caf_pkg::*;
#(
  parameter int i_bits      = 24,
  parameter int q_bits      = 24,
  parameter int length      = CAF_LENGTH,
  parameter int length_bits = clog2(length),
  parameter int shift       = 0,
  parameter int out_i_bits  = i_bits + length_bits - shift,
  parameter int out_q_bits  = q_bits + length_bits - shift
) (
  input  logic              clk,
  input  logic              reset,
  cpx_accumulate_if.slave   bus,
  output acc_state_e        dbg_state_o
);
  localparam logic [length_bits-1:0] last_count = length_bits'(length - 1);

  acc_state_e             state_q, state_d;
  logic [length_bits-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   last_q;
  logic                   accept, last, out_take;
  logic                   load_out, park, unpark;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    count_d  = count_q;
    load_out = 1'b0;
    park     = 1'b0;
    unpark   = 1'b0;
    accept   = bus.m_axis_tvalid && (state_q == ACC);
    last     = accept && (count_q == last_count);
    out_take = valid_q && bus.m_axis_tready;

    if (accept) count_d = last ? '0 : count_q + 1'b1;

    case (state_q)
      ACC: begin
        if (last) begin
          // A finished sum that cannot reach the output yet is parked.
          if (valid_q && !bus.m_axis_tready) begin
            park    = 1'b1;
            state_d = HOLD;
          end else begin
            load_out = 1'b1;
            valid_d  = 1'b1;
          end
        end else if (out_take) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.m_axis_tready) begin
          unpark  = 1'b1;
          state_d = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last;
    end
  end

  cpx_acc_lane #(
    .in_bits(i_bits), .length_bits(length_bits), .shift(shift), .out_bits(out_i_bits)
  ) u_lane_i (
    .clk(clk), .reset(reset), .sample_i(bus.i), .accept_i(accept),
    .first_i(count_q == '0), .load_out_i(load_out), .park_i(park),
    .unpark_i(unpark), .sum_o(bus.i_sum)
  );

  cpx_acc_lane #(
    .in_bits(q_bits), .length_bits(length_bits), .shift(shift), .out_bits(out_q_bits)
  ) u_lane_q (
    .clk(clk), .reset(reset), .sample_i(bus.q), .accept_i(accept),
    .first_i(count_q == '0), .load_out_i(load_out), .park_i(park),
    .unpark_i(unpark), .sum_o(bus.q_sum)
  );

  assign bus.s_axis_tready = (state_q == ACC);
  assign bus.s_axis_tvalid = valid_q;
  assign bus.block_last    = last_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_cpx_accumulate.sv
// Bench for cpx_accumulate: three configurations share one stimulus bus;
// directed steps followed by a randomized run against a block-sum model.
module tb_cpx_accumulate;
  import caf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tv, rdy;
  logic [23:0] in_i, in_q;
  acc_state_e  st4, st4s, st5;
  int          vectors = 0;
  int          errs    = 0;
  logic [26:0] exp_isum_q[$];
  logic [26:0] exp_qsum_q[$];

  always #5 clk = ~clk;

  cpx_accumulate_if #(.i_bits(24), .q_bits(24), .out_i_bits(26), .out_q_bits(26)) bus4 ();
  cpx_accumulate_if #(.i_bits(24), .q_bits(24), .out_i_bits(24), .out_q_bits(24)) bus4s ();
  cpx_accumulate_if #(.i_bits(24), .q_bits(24), .out_i_bits(27), .out_q_bits(27)) bus5 ();

  assign bus4.m_axis_tvalid  = tv;  assign bus4.m_axis_tready  = rdy;
  assign bus4.i  = in_i;            assign bus4.q  = in_q;
  assign bus4s.m_axis_tvalid = tv;  assign bus4s.m_axis_tready = rdy;
  assign bus4s.i = in_i;            assign bus4s.q = in_q;
  assign bus5.m_axis_tvalid  = tv;  assign bus5.m_axis_tready  = rdy;
  assign bus5.i  = in_i;            assign bus5.q  = in_q;

  cpx_accumulate #(.i_bits(24), .q_bits(24), .length(4), .length_bits(2), .shift(0),
                   .out_i_bits(26), .out_q_bits(26))
    u_d4 (.clk(clk), .reset(reset), .bus(bus4), .dbg_state_o(st4));
  cpx_accumulate #(.i_bits(24), .q_bits(24), .length(4), .length_bits(2), .shift(2),
                   .out_i_bits(24), .out_q_bits(24))
    u_d4s (.clk(clk), .reset(reset), .bus(bus4s), .dbg_state_o(st4s));
  cpx_accumulate #(.i_bits(24), .q_bits(24), .length(5), .length_bits(3), .shift(0),
                   .out_i_bits(27), .out_q_bits(27))
    u_d5 (.clk(clk), .reset(reset), .bus(bus5), .dbg_state_o(st5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic send(input int a, input int b);
    tv   = 1'b1;
    in_i = 24'(a);
    in_q = 24'(b);
    tick();
  endtask

  task automatic send_block(input int a, input int b, input int n);
    for (int k = 0; k < n; k++) send(a, b);
    tv = 1'b0;
  endtask

  task automatic do_reset();
    tv    = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic signed [63:0] si, sq;
    int  sent, acc_cnt, blocks, guard;
    bit  take;

    tv = 1'b0; rdy = 1'b0; in_i = '0; in_q = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_i_sum", $signed(bus4.i_sum), 0);
    chk("rst_q_sum", $signed(bus4.q_sum), 0);
    chk("rst_valid", bus4.s_axis_tvalid, 0);
    chk("rst_last", bus4.block_last, 0);
    chk("rst_ready", bus4.s_axis_tready, 1);

    // Basic block, ready high
    rdy = 1'b1;
    send(1, -1); send(2, -2); send(3, -3); send(4, -4);
    tv = 1'b0;
    chk("blk1_i", $signed(bus4.i_sum), 10);
    chk("blk1_q", $signed(bus4.q_sum), -10);
    chk("blk1_valid", bus4.s_axis_tvalid, 1);
    chk("blk1_last", bus4.block_last, 1);
    tick();
    chk("blk1_last_clr", bus4.block_last, 0);
    chk("blk1_valid_clr", bus4.s_axis_tvalid, 0);
    send_block(3, -3, 4);
    chk("blk2_fresh_i", $signed(bus4.i_sum), 12);
    chk("blk2_fresh_q", $signed(bus4.q_sum), -12);

    // Extreme inputs, held pending, then discarded by reset
    do_reset();
    rdy = 1'b0;
    send_block(-(1 << 23), (1 << 23) - 1, 4);
    chk("ext_i", $signed(bus4.i_sum), -(64'sd1 <<< 25));
    chk("ext_q", $signed(bus4.q_sum), 4 * ((64'sd1 <<< 23) - 1));
    tick();
    chk("ext_hold", $signed(bus4.i_sum), -(64'sd1 <<< 25));
    do_reset();
    chk("rst_pend_valid", bus4.s_axis_tvalid, 0);
    chk("rst_pend_sum", $signed(bus4.i_sum), 0);

    // Back-pressure across two blocks
    rdy = 1'b0;
    send_block(1, -1, 4);
    chk("bp_first", $signed(bus4.i_sum), 4);
    for (int k = 0; k < 4; k++) begin
      chk("bp_ready_before", bus4.s_axis_tready, 1);
      send(2, -2);
    end
    tv = 1'b0;
    chk("bp_ready_drop", bus4.s_axis_tready, 0);
    chk("bp_state", st4, HOLD);
    tick(); tick();
    chk("bp_stable_i", $signed(bus4.i_sum), 4);
    chk("bp_stable_valid", bus4.s_axis_tvalid, 1);
    rdy = 1'b1;
    tick();
    chk("bp_second_i", $signed(bus4.i_sum), 8);
    chk("bp_second_q", $signed(bus4.q_sum), -8);
    chk("bp_second_valid", bus4.s_axis_tvalid, 1);
    chk("bp_ready_back", bus4.s_axis_tready, 1);
    tick();
    chk("bp_drained", bus4.s_axis_tvalid, 0);

    // Reset mid-block
    send_block(7, 7, 2);
    do_reset();
    send_block(5, 5, 4);
    chk("midrst_i", $signed(bus4.i_sum), 20);

    // Shift / rounding
    do_reset();
    send_block(1, -3, 4);
    chk("sh_i", $signed(bus4s.i_sum), 1);
    chk("sh_q", $signed(bus4s.q_sum), -3);
    tick();
    send(1, -1); send(2, -2); send(2, -2); send(1, -1);
    tv = 1'b0;
`ifdef CPX_ACCUMULATE_ROUND_EN
    chk("sh_rnd_i", $signed(bus4s.i_sum), 2);
    chk("sh_rnd_q", $signed(bus4s.q_sum), -1);
`else
    chk("sh_flr_i", $signed(bus4s.i_sum), 1);
    chk("sh_flr_q", $signed(bus4s.q_sum), -2);
`endif

    // Randomized run, length 5: the driver holds each sample until taken,
    // so the model just sums every intended sample in groups of five.
    do_reset();
    si = 0; sq = 0; sent = 0; acc_cnt = 0; blocks = 0; guard = 0;
    rdy = 1'b1;
    while ((sent < 5000 || tv || exp_isum_q.size() != 0) && guard < 60000) begin
      take = 1'b0;
      if (tv && bus5.s_axis_tready) begin
        si += $signed(in_i);
        sq += $signed(in_q);
        acc_cnt++;
        sent++;
        take = 1'b1;
        if (acc_cnt == 5) begin
          exp_isum_q.push_back(si[26:0]);
          exp_qsum_q.push_back(sq[26:0]);
          acc_cnt = 0; si = 0; sq = 0;
        end
      end
      if (bus5.s_axis_tvalid && rdy) begin
        chk("rand_has_exp", exp_isum_q.size() > 0, 1);
        if (exp_isum_q.size() > 0) begin
          chk("rand_i", $signed(bus5.i_sum), $signed(exp_isum_q.pop_front()));
          chk("rand_q", $signed(bus5.q_sum), $signed(exp_qsum_q.pop_front()));
          blocks++;
        end
      end
      tick();
      guard++;
      if (take || !tv) begin
        if (sent < 5000 && $urandom_range(0, 3) != 0) begin
          tv   = 1'b1;
          in_i = 24'($urandom);
          in_q = 24'($urandom);
        end else begin
          tv = 1'b0;
        end
      end
      rdy = (sent >= 5000) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    chk("rand_timeout", guard < 60000, 1);
    chk("rand_blocks", blocks, 1000);
    chk("rand_leftover", exp_isum_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
